// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU (alu_seq) and its
// iterative shift/multiply unit (alu_iter_unit).
//   - OP_W          : operation-code width
//   - OP_*          : operation codes
//   - state_t       : control states of alu_seq
// Optional feature macro: ALU_SEQ_MUL_EN adds the MUL state (op 11).
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd11;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: multi-cycle working register for alu_seq.
// Shifts one bit per cycle (SLL/SRL/SRA); with ALU_SEQ_MUL_EN it also runs an
// unsigned shift-add multiply, one multiplier bit per cycle, WIDTH cycles.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : load operands and begin (pulse, only from alu_seq IDLE)
//   op             : operation being started
//   a              : operand A (value to shift / multiplicand)
//   shamt          : shift amount, must be non-zero when start is used for a shift
//   b              : multiplier (ALU_SEQ_MUL_EN only)
//   done           : the step taken this cycle is the last one
//   result         : value after this cycle's step (meaningful when done)
//   hi_nz          : upper product half is non-zero (ALU_SEQ_MUL_EN only)
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
`ifdef ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] b,
  output logic             hi_nz,
`endif
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // Counter must hold WIDTH for the multiply, hence one bit more than SHW.
  localparam int CW = SHW + 1;

  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_step_s;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_step_s;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     part_s;

  // One shift-add step: add multiplicand into the high half when the current
  // multiplier bit (prod lsb) is set, then shift the whole product right.
  always_comb begin
    part_s      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step_s = {part_s, prod_q[WIDTH-1:1]};
  end
`endif

  // One-bit step of the shifter.
  always_comb begin
    case (op_q)
      OP_SLL:  shift_step_s = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, work_q[WIDTH-1:1]};
      // The top bit never changes under SRA, so it still holds the original sign.
      OP_SRA:  shift_step_s = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_step_s = work_q;
    endcase
  end

  // Load on start, otherwise step while the counter is non-zero.
  always_comb begin
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
`ifdef ALU_SEQ_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
`endif
    if (start) begin
      op_d   = op;
      work_d = a;
      cnt_d  = {1'b0, shamt};
`ifdef ALU_SEQ_MUL_EN
      prod_d  = {{WIDTH{1'b0}}, b};
      mcand_d = a;
      if (op == OP_MUL) begin
        cnt_d = CW'(WIDTH);
      end else begin
        cnt_d = {1'b0, shamt};
      end
`endif
    end else if (cnt_q != {CW{1'b0}}) begin
      work_d = shift_step_s;
      cnt_d  = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
      prod_d = prod_step_s;
`endif
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Result and completion flag seen by alu_seq.
  always_comb begin
    done = (cnt_q == CW'(1));
`ifdef ALU_SEQ_MUL_EN
    hi_nz = |prod_step_s[2*WIDTH-1:WIDTH];
    if (op_q == OP_MUL) begin
      result = prod_step_s[WIDTH-1:0];
    end else begin
      result = shift_step_s;
    end
`else
    result = shift_step_s;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_AND;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= {(2*WIDTH){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
`endif
    end else begin
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request handshake and a one-cycle
// out_valid pulse. Logic, add/sub, signed/unsigned compare complete in one
// cycle; non-zero shifts run one bit per cycle in alu_iter_unit.
// Optional feature macro: ALU_SEQ_MUL_EN enables op 11 (MUL, WIDTH cycles).
// WIDTH must be a power of 2 and at least 4.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready high only in IDLE)
//   alu_op, a, b        : operation and operands (b[SHW-1:0] = shift amount)
//   out_valid           : one-cycle pulse when f and flags update
//   f, zf, of, cf       : result and flags, held between out_valid pulses
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             of,
  output logic             cf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zf_q, zf_d;
  logic             of_q, of_d;
  logic             cf_q, cf_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] single_f_s;
  logic             single_of_s;
  logic             single_cf_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_shift_s;
  logic             is_mul_s;
  logic             iter_op_s;
  logic             iter_start_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_result_s;
`ifdef ALU_SEQ_MUL_EN
  logic             iter_hi_nz_s;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign zf        = zf_q;
  assign of        = of_q;
  assign cf        = cf_q;

  assign shamt_s    = b[SHW-1:0];
  assign is_shift_s = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
`ifdef ALU_SEQ_MUL_EN
  assign is_mul_s   = (alu_op == OP_MUL);
`else
  assign is_mul_s   = 1'b0;
`endif
  // Zero-amount shifts finish in one cycle; only real work goes iterative.
  assign iter_op_s    = (is_shift_s && (shamt_s != {SHW{1'b0}})) || is_mul_s;
  assign iter_start_s = in_valid && (state_q == ST_IDLE) && iter_op_s;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start_s),
    .op     (alu_op),
    .a      (a),
    .shamt  (shamt_s),
`ifdef ALU_SEQ_MUL_EN
    .b      (b),
    .hi_nz  (iter_hi_nz_s),
`endif
    .done   (iter_done_s),
    .result (iter_result_s)
  );

  // Single-cycle result and flags for the op currently presented.
  always_comb begin
    sum_s       = {1'b0, a} + {1'b0, b};
    diff_s      = {1'b0, a} - {1'b0, b};
    single_f_s  = {WIDTH{1'b0}};
    single_of_s = 1'b0;
    single_cf_s = 1'b0;
    case (alu_op)
      OP_AND:  single_f_s = a & b;
      OP_OR:   single_f_s = a | b;
      OP_XOR:  single_f_s = a ^ b;
      OP_NOR:  single_f_s = ~(a | b);
      OP_ADD: begin
        single_f_s  = sum_s[WIDTH-1:0];
        single_cf_s = sum_s[WIDTH];
        single_of_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        single_f_s  = diff_s[WIDTH-1:0];
        // The extra bit of the widened subtraction is the unsigned borrow.
        single_cf_s = diff_s[WIDTH];
        single_of_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  single_f_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: single_f_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: single_f_s = a;
      default: single_f_s = {WIDTH{1'b0}};
    endcase
  end

  // Control: accept in IDLE, wait for the iterative unit in SHIFT/MUL.
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    of_d        = of_q;
    cf_d        = cf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && iter_op_s) begin
`ifdef ALU_SEQ_MUL_EN
          state_d = is_mul_s ? ST_MUL : ST_SHIFT;
`else
          state_d = ST_SHIFT;
`endif
        end else if (in_valid) begin
          f_d         = single_f_s;
          of_d        = single_of_s;
          cf_d        = single_cf_s;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (iter_done_s) begin
          state_d     = ST_IDLE;
          f_d         = iter_result_s;
          of_d        = 1'b0;
          cf_d        = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (iter_done_s) begin
          state_d     = ST_IDLE;
          f_d         = iter_result_s;
          of_d        = 1'b0;
          cf_d        = iter_hi_nz_s;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_MUL;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // zf follows the new f only when a result is published.
    zf_d = out_valid_d ? (f_d == {WIDTH{1'b0}}) : zf_q;
  end

  // Registered state, result and flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      f_q         <= {WIDTH{1'b0}};
      zf_q        <= 1'b1;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      cf_q        <= cf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32). The driver pushes the
// expected response (from constants or a behavioural model) when a request is
// accepted; a monitor pops and compares on every out_valid, including the
// cycle on which the result is expected to appear.
module tb_alu_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] f;
    logic         zf;
    logic         of;
    logic         cf;
    int           lat;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] f;
  logic         zf;
  logic         of;
  logic         cf;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .f         (f),
    .zf        (zf),
    .of        (of),
    .cf        (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t mk(input logic [W-1:0] fv, input logic z, input logic o,
                              input logic c, input int lat);
    exp_t e;
    e.f = fv; e.zf = z; e.of = o; e.cf = c; e.lat = lat; e.cyc = 0;
    return e;
  endfunction

  // Reference model straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t           e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             sh;
    e.f = '0; e.of = 1'b0; e.cf = 1'b0; e.lat = 1; e.cyc = 0;
    sh = int'(y % W);
    s = '0;
    p = '0;
    case (op)
      4'd0: e.f = x & y;
      4'd1: e.f = x | y;
      4'd2: e.f = x ^ y;
      4'd3: e.f = ~(x | y);
      4'd4: begin
        s = {1'b0, x} + {1'b0, y};
        e.f = s[W-1:0]; e.cf = s[W];
        e.of = (x[W-1] == y[W-1]) && (e.f[W-1] != x[W-1]);
      end
      4'd5: begin
        e.f = x - y; e.cf = (x < y);
        e.of = (x[W-1] != y[W-1]) && (e.f[W-1] != x[W-1]);
      end
      4'd6:  e.f = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd7:  begin e.f = x << sh; e.lat = 1 + sh; end
      4'd8:  begin e.f = x >> sh; e.lat = 1 + sh; end
      4'd9:  begin e.f = $signed(x) >>> sh; e.lat = 1 + sh; end
      4'd10: e.f = (x < y) ? W'(1) : W'(0);
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.f = p[W-1:0]; e.cf = |p[2*W-1:W]; e.lat = W + 1;
      end
`endif
      default: e.f = '0;
    endcase
    e.zf = (e.f == '0);
    return e;
  endfunction

  // Called at #1 after a clock edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e_in, input bit push);
    exp_t e;
    int   waited;
    e = e_in;
    alu_op = op; a = x; b = y; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.cyc = cyc + e.lat - 1;
      if (push) sb.push_back(e);
      chk("in_ready_after_accept", 64'(in_ready), 64'(e.lat == 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: f=%0h with no request pending (cycle %0d)", f, cyc);
      end else begin
        e = sb.pop_front();
        chk("f", 64'(f), 64'(e.f));
        chk("zf", 64'(zf), 64'(e.zf));
        chk("of", 64'(of), 64'(e.of));
        chk("cf", 64'(cf), 64'(e.cf));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    rst = 1'b1; in_valid = 1'b0; alu_op = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_f", 64'(f), 64'd0);
    chk("reset_zf", 64'(zf), 64'd1);
    chk("reset_of", 64'(of), 64'd0);
    chk("reset_cf", 64'(cf), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations.
    issue(4'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    issue(4'd0, 32'h0, 32'h0, mk(32'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    issue(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0001, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    issue(4'd5, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h1, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    issue(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, mk(32'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    issue(4'd7, 32'h0000_0003, 32'h0000_0004, mk(32'h30, 1'b0, 1'b0, 1'b0, 5), 1'b1);
    issue(4'd9, 32'h8000_0000, 32'h0000_001F, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32), 1'b1);
    issue(4'd8, 32'h8000_0000, 32'h0000_001F, mk(32'h1, 1'b0, 1'b0, 1'b0, 32), 1'b1);
    issue(4'd7, 32'h1234_5678, 32'h0000_0020, mk(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1), 1'b1);
`ifdef ALU_SEQ_MUL_EN
    issue(4'd11, 32'h0001_2345, 32'h0000_0010, mk(32'h0012_3450, 1'b0, 1'b0, 1'b0, 33), 1'b1);
    issue(4'd11, 32'h8000_0000, 32'h8000_0000, mk(32'h0, 1'b1, 1'b0, 1'b1, 33), 1'b1);
`else
    issue(4'd11, 32'h0001_2345, 32'h0000_0010, mk(32'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
`endif
    drain();

    // Reset in the middle of a 16-step shift: no result may ever appear.
    issue(4'd7, 32'h0000_0001, 32'h0000_0010, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0, 17), 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midshift_reset_f", 64'(f), 64'd0);
    chk("midshift_reset_zf", 64'(zf), 64'd1);
    chk("midshift_reset_in_ready", 64'(in_ready), 64'd1);
    chk("midshift_reset_out_valid", 64'(out_valid), 64'd0);
    repeat (20) @(posedge clk);
    #1;

    // Randomized traffic against the model, with idle gaps.
    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = rnd_val();
      y  = rnd_val();
      if ($urandom_range(0, 3) == 0) y = W'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        a = W'($urandom);
        @(posedge clk); #1;
      end
      issue(op, x, y, model(op, x, y), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
